// File: rtl/hazard_scoreboard_if.sv
// Hazard-unit signal bundle: D/E/M/W register tags and mul/div events in,
// stall/forward/status out. The datapath holds master, the hazard unit holds slave.
interface hazard_scoreboard_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic [AW-1:0]    rs_d;
    logic [AW-1:0]    rt_d;
    logic [AW-1:0]    rs_e;
    logic [AW-1:0]    rt_e;
    logic [AW-1:0]    write_reg_e;
    logic [AW-1:0]    write_reg_m;
    logic [AW-1:0]    write_reg_w;
    logic             reg_write_e;
    logic             reg_write_m;
    logic             reg_write_w;
    logic             memtoreg_e;
    logic             memtoreg_m;
    logic             branch_d;
    logic             md_op_d;
    logic             md_start_e;
    logic [AW-1:0]    md_dst_e;
    logic             md_done;
    logic             stat_clr;
    logic             stall_f;
    logic             stall_d;
    logic             flush_e;
    logic             forward_ad;
    logic             forward_bd;
    logic [1:0]       forward_ae;
    logic [1:0]       forward_be;
    logic             md_busy;
    logic             md_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, memtoreg_e, memtoreg_m,
               branch_d, md_op_d, md_start_e, md_dst_e, md_done, stat_clr,
        input  stall_f, stall_d, flush_e, forward_ad, forward_bd, forward_ae,
               forward_be, md_busy, md_err, stall_cycles
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
               reg_write_e, reg_write_m, reg_write_w, memtoreg_e, memtoreg_m,
               branch_d, md_op_d, md_start_e, md_dst_e, md_done, stat_clr,
        output stall_f, stall_d, flush_e, forward_ad, forward_bd, forward_ae,
               forward_be, md_busy, md_err, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS core with an in-order mul/div scoreboard.
// Build macro HAZARD_FWD_EN enables forwarding; without it M/E RAW hazards stall instead.
module hazard_scoreboard #(
    parameter int AW       = 5,
    parameter int MD_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);
    localparam int               PW       = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam int               CW       = $clog2(MD_DEPTH + 1);
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_FULL = CW'(MD_DEPTH);
    localparam logic [CW-1:0]    CNT_NEAR = CW'(MD_DEPTH - 1);
    localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PTR_LAST = PW'(MD_DEPTH - 1);
    localparam logic [AW-1:0]    REG_ZERO = {AW{1'b0}};
    localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};

    // Register 0 is hard-wired zero and never creates a dependency.
    function automatic logic src_hit(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                     input logic [AW-1:0] x);
        return ((rs != REG_ZERO) && (rs == x)) || ((rt != REG_ZERO) && (rt == x));
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? PTR_ZERO : p + PW'(1);
    endfunction

    logic [MD_DEPTH-1:0]         valid_q, valid_d;
    logic [MD_DEPTH-1:0][AW-1:0] dst_q, dst_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        md_busy_q, md_busy_d;
    logic                        md_err_q, md_err_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

    logic       lw_stall_s, br_stall_s, sb_stall_s, st_stall_s, raw_stall_s, stall_s;
    logic       do_push_s, do_pop_s;
    logic       fwd_ad_s, fwd_bd_s;
    logic [1:0] fwd_ae_s, fwd_be_s;

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                           input logic [AW-1:0] dst_m, input logic we_m,
                                           input logic [AW-1:0] dst_w, input logic we_w);
        logic [1:0] sel;
        if ((src != REG_ZERO) && (src == dst_m) && we_m) begin
            sel = 2'b10;
        end else if ((src != REG_ZERO) && (src == dst_w) && we_w) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Forward selects; M wins over W in the E stage.
    always_comb begin
        fwd_ae_s    = fwd_sel(hz.rs_e, hz.write_reg_m, hz.reg_write_m, hz.write_reg_w, hz.reg_write_w);
        fwd_be_s    = fwd_sel(hz.rt_e, hz.write_reg_m, hz.reg_write_m, hz.write_reg_w, hz.reg_write_w);
        fwd_ad_s    = (hz.rs_d != REG_ZERO) && (hz.rs_d == hz.write_reg_m) && hz.reg_write_m;
        fwd_bd_s    = (hz.rt_d != REG_ZERO) && (hz.rt_d == hz.write_reg_m) && hz.reg_write_m;
        raw_stall_s = 1'b0;
    end
`else
    logic fwd_unused_s;
    assign fwd_unused_s = ^{hz.rs_e, hz.write_reg_w, hz.reg_write_w};

    // No bypass paths: D-stage readers wait out producers in E and M (regfile is write-first).
    always_comb begin
        fwd_ae_s    = 2'b00;
        fwd_be_s    = 2'b00;
        fwd_ad_s    = 1'b0;
        fwd_bd_s    = 1'b0;
        raw_stall_s = (hz.reg_write_e && src_hit(hz.rs_d, hz.rt_d, hz.write_reg_e)) ||
                      (hz.reg_write_m && src_hit(hz.rs_d, hz.rt_d, hz.write_reg_m));
    end
`endif

    // Stall terms; an entry being popped this cycle still blocks until next cycle.
    always_comb begin
        lw_stall_s = hz.memtoreg_e && src_hit(hz.rs_d, hz.rt_d, hz.rt_e);
        br_stall_s = hz.branch_d &&
                     ((hz.reg_write_e && src_hit(hz.rs_d, hz.rt_d, hz.write_reg_e)) ||
                      (hz.memtoreg_m  && src_hit(hz.rs_d, hz.rt_d, hz.write_reg_m)));
        sb_stall_s = hz.md_start_e && src_hit(hz.rs_d, hz.rt_d, hz.md_dst_e);
        for (int i = 0; i < MD_DEPTH; i++) begin
            sb_stall_s = sb_stall_s | (valid_q[i] & src_hit(hz.rs_d, hz.rt_d, dst_q[i]));
        end
        st_stall_s = hz.md_op_d &&
                     ((count_q == CNT_FULL) || ((count_q == CNT_NEAR) && hz.md_start_e));
        stall_s    = lw_stall_s | br_stall_s | sb_stall_s | st_stall_s | raw_stall_s;
    end

    // Scoreboard FIFO and status next-state; a pop frees the slot a same-cycle push reuses.
    always_comb begin
        do_pop_s  = hz.md_done && (count_q != CNT_ZERO);
        do_push_s = hz.md_start_e && ((count_q != CNT_FULL) || do_pop_s);
        valid_d   = valid_q;
        dst_d     = dst_q;
        md_err_d  = md_err_q | (hz.md_start_e & ~do_push_s) | (hz.md_done & ~do_pop_s);

        if (do_pop_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_next(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (do_push_s) begin
            valid_d[wr_ptr_q] = 1'b1;
            dst_d[wr_ptr_q]   = hz.md_dst_e;
            wr_ptr_d          = ptr_next(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        md_busy_d = (count_d != CNT_ZERO);

        if (hz.stat_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_q != STAT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= {MD_DEPTH{1'b0}};
            dst_q       <= {(MD_DEPTH*AW){1'b0}};
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            md_busy_q   <= 1'b0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            dst_q       <= dst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            md_busy_q   <= md_busy_d;
            md_err_q    <= md_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_f      = stall_s;
    assign hz.stall_d      = stall_s;
    assign hz.flush_e      = stall_s;
    assign hz.forward_ad   = fwd_ad_s;
    assign hz.forward_bd   = fwd_bd_s;
    assign hz.forward_ae   = fwd_ae_s;
    assign hz.forward_be   = fwd_be_s;
    assign hz.md_busy      = md_busy_q;
    assign hz.md_err       = md_err_q;
    assign hz.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expectations follow HAZARD_FWD_EN the same way as the build.
module tb_hazard_scoreboard;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    always #10 clk = ~clk;

    hazard_scoreboard_if #(.AW(AW), .CNT_W(CNT_W)) hz ();

    hazard_scoreboard #(.AW(AW), .MD_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL queue_empty: observed %0h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic check_stall(input string tag, input logic e);
        push_exp({tag, "_stall_f"}, 32'(e));
        push_exp({tag, "_stall_d"}, 32'(e));
        push_exp({tag, "_flush_e"}, 32'(e));
        check(32'(hz.stall_f));
        check(32'(hz.stall_d));
        check(32'(hz.flush_e));
    endtask

    task automatic check_cnt(input string tag);
        push_exp(tag, 32'(exp_cnt));
        check(32'(hz.stall_cycles));
    endtask

    // Clock edge; the counter model follows the stall the bench expected for this cycle.
    task automatic tick(input logic exp_stall);
        @(posedge clk);
        if (hz.stat_clr) exp_cnt = 0;
        else if (exp_stall && exp_cnt != CMAX) exp_cnt++;
        #1;
    endtask

    task automatic idle();
        hz.rs_d = '0; hz.rt_d = '0; hz.rs_e = '0; hz.rt_e = '0;
        hz.write_reg_e = '0; hz.write_reg_m = '0; hz.write_reg_w = '0;
        hz.reg_write_e = 1'b0; hz.reg_write_m = 1'b0; hz.reg_write_w = 1'b0;
        hz.memtoreg_e = 1'b0; hz.memtoreg_m = 1'b0; hz.branch_d = 1'b0;
        hz.md_op_d = 1'b0; hz.md_start_e = 1'b0; hz.md_dst_e = '0;
        hz.md_done = 1'b0; hz.stat_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        push_exp("rst_busy", 32'd0); check(32'(hz.md_busy));
        push_exp("rst_err", 32'd0);  check(32'(hz.md_err));
        check_cnt("rst_cnt");
        check_stall("rst", 1'b0);
        reset = 1'b0;
        #1;

        // load-use
        hz.rt_e = 5'd5; hz.memtoreg_e = 1'b1; hz.rs_d = 5'd5; #1;
        check_stall("lw", 1'b1);
        tick(1'b1);
        idle(); #1;
        check_stall("lw_after", 1'b0);
        check_cnt("lw_cnt");
        hz.memtoreg_e = 1'b1; #1;
        check_stall("lw_r0", 1'b0);
        idle(); #1;

        // forwarding / raw stall
        hz.rs_e = 5'd3; hz.write_reg_m = 5'd3; hz.reg_write_m = 1'b1;
        hz.write_reg_w = 5'd3; hz.reg_write_w = 1'b1; #1;
        push_exp("fae_m", FWD ? 32'd2 : 32'd0); check(32'(hz.forward_ae));
        hz.reg_write_m = 1'b0; #1;
        push_exp("fae_w", FWD ? 32'd1 : 32'd0); check(32'(hz.forward_ae));
        hz.rs_e = 5'd0; hz.reg_write_m = 1'b1; #1;
        push_exp("fae_r0", 32'd0); check(32'(hz.forward_ae));
        hz.rt_e = 5'd3; #1;
        push_exp("fbe_m", FWD ? 32'd2 : 32'd0); check(32'(hz.forward_be));
        check_stall("fwd_e", 1'b0);
        idle();
        hz.rs_d = 5'd4; hz.write_reg_m = 5'd4; hz.reg_write_m = 1'b1; #1;
        push_exp("fad", 32'(FWD)); check(32'(hz.forward_ad));
        check_stall("raw_m", !FWD);
        hz.rs_d = 5'd0; hz.rt_d = 5'd4; #1;
        push_exp("fbd", 32'(FWD)); check(32'(hz.forward_bd));
        hz.rt_d = 5'd0; hz.write_reg_m = 5'd0; #1;
        push_exp("fad_r0", 32'd0); check(32'(hz.forward_ad));
        check_stall("raw_r0", 1'b0);
        idle();
        hz.rs_d = 5'd6; hz.write_reg_e = 5'd6; hz.reg_write_e = 1'b1; #1;
        check_stall("raw_e", !FWD);
        hz.branch_d = 1'b1; #1;
        check_stall("br_e", 1'b1);
        hz.reg_write_e = 1'b0; hz.memtoreg_m = 1'b1; hz.write_reg_m = 5'd6; #1;
        check_stall("br_m", 1'b1);
        idle(); #1;

        // scoreboard RAW
        hz.md_start_e = 1'b1; hz.md_dst_e = 5'd7; hz.rs_d = 5'd7; #1;
        check_stall("sb_issue", 1'b1);
        push_exp("sb_busy0", 32'd0); check(32'(hz.md_busy));
        tick(1'b1);
        hz.md_start_e = 1'b0; #1;
        check_stall("sb_wait", 1'b1);
        push_exp("sb_busy1", 32'd1); check(32'(hz.md_busy));
        tick(1'b1);
        hz.md_done = 1'b1; #1;
        check_stall("sb_done", 1'b1);
        tick(1'b1);
        hz.md_done = 1'b0; #1;
        check_stall("sb_clear", 1'b0);
        push_exp("sb_busy2", 32'd0); check(32'(hz.md_busy));
        push_exp("sb_err", 32'd0); check(32'(hz.md_err));
        check_cnt("sb_cnt");
        idle(); #1;

        // structural full, push+pop, push-when-full, wrap and drain
        for (int i = 0; i < DEPTH; i++) begin
            hz.md_start_e = 1'b1; hz.md_dst_e = 5'(8 + i); hz.md_op_d = (i >= 2); #1;
            check_stall("st_fill", i == DEPTH - 1);
            tick(i == DEPTH - 1);
        end
        hz.md_start_e = 1'b0; hz.md_op_d = 1'b1; #1;
        check_stall("st_full", 1'b1);
        hz.md_start_e = 1'b1; hz.md_done = 1'b1; hz.md_dst_e = 5'd12; #1;
        check_stall("st_pushpop", 1'b1);
        tick(1'b1);
        hz.md_start_e = 1'b0; hz.md_done = 1'b0; #1;
        check_stall("st_still_full", 1'b1);
        hz.md_op_d = 1'b0; hz.rs_d = 5'd8; #1;
        check_stall("sb_popped8", 1'b0);
        hz.rs_d = 5'd12; #1;
        check_stall("sb_has12", 1'b1);
        hz.rs_d = 5'd0; hz.md_start_e = 1'b1; hz.md_dst_e = 5'd13; #1;
        tick(1'b0);
        hz.md_start_e = 1'b0; hz.rt_d = 5'd13; #1;
        check_stall("sb_full_drop", 1'b0);
        push_exp("err_push_full", 32'd1); check(32'(hz.md_err));
        hz.rt_d = 5'd0; hz.md_done = 1'b1;
        repeat (DEPTH) tick(1'b0);
        hz.md_done = 1'b0; hz.rs_d = 5'd12; #1;
        check_stall("sb_drained", 1'b0);
        push_exp("drain_busy", 32'd0); check(32'(hz.md_busy));
        check_cnt("st_cnt");
        idle();

        // reset, pop-when-empty, reset with entries held
        reset = 1'b1; #1;
        exp_cnt = 0;
        push_exp("rst2_err", 32'd0); check(32'(hz.md_err));
        check_cnt("rst2_cnt");
        reset = 1'b0; #1;
        hz.md_done = 1'b1;
        tick(1'b0);
        hz.md_done = 1'b0; #1;
        push_exp("err_pop_empty", 32'd1); check(32'(hz.md_err));
        push_exp("pop_empty_busy", 32'd0); check(32'(hz.md_busy));
        for (int i = 0; i < 3; i++) begin
            hz.md_start_e = 1'b1; hz.md_dst_e = 5'(20 + i);
            tick(1'b0);
        end
        hz.md_start_e = 1'b0; hz.rs_d = 5'd21; #1;
        check_stall("held3", 1'b1);
        push_exp("held3_busy", 32'd1); check(32'(hz.md_busy));
        reset = 1'b1; #1;
        check_stall("rst3", 1'b0);
        push_exp("rst3_busy", 32'd0); check(32'(hz.md_busy));
        push_exp("rst3_err", 32'd0); check(32'(hz.md_err));
        reset = 1'b0;
        idle(); #1;

        // counter saturation and clear priority
        hz.rt_e = 5'd5; hz.memtoreg_e = 1'b1; hz.rs_d = 5'd5;
        repeat (CMAX + 4) tick(1'b1);
        check_cnt("cnt_sat");
        hz.stat_clr = 1'b1;
        tick(1'b1);
        check_cnt("cnt_clr");
        hz.stat_clr = 1'b0;
        tick(1'b1);
        check_cnt("cnt_restart");
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
